// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file sequencer of the matrix divider.
// The file is 16x32 with a single write port and nine asynchronous read ports.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;
  localparam int RF_NREAD  = 9;
  localparam int RF_CNT_W  = $clog2(RF_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_WB,
    ST_DONE
  } rf_seq_state_t;

endpackage

// File: rtl/rf_wdt_cnt.sv
// Watchdog for the compute phase: counts cycles while run is high and
// flags the final permitted cycle. The count restarts from zero whenever run drops.
module rf_wdt_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (run) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/rf_seq_ctrl.sv
// Sequencer owning the register file write port: loads nine operands, starts the
// divider core, writes the results back and reports done or a watchdog timeout.
module rf_seq_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_LOAD   = RF_NREAD,
  parameter int N_RES    = 3,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 12,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_wa,
  output logic [DATA_W-1:0]            rf_wd,
  output logic [RF_NREAD*ADDR_W-1:0]   rf_ra,
  output logic                         calc_start,
  input  logic                         calc_done,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [DATA_W-1:0]            res_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam logic [RF_CNT_W-1:0] LAST_LOAD = RF_CNT_W'(N_LOAD - 1);
  localparam logic [RF_CNT_W-1:0] LAST_RES  = RF_CNT_W'(N_RES - 1);

  rf_seq_state_t state_q, state_d;
  logic [RF_CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic in_ready_q, in_ready_d;
  logic res_ready_q, res_ready_d;
  logic calc_start_q, calc_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [RF_NREAD*ADDR_W-1:0] rf_ra_q, rf_ra_d;

  logic load_acc;
  logic wb_acc;
  logic wdt_expired;

  rf_wdt_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == ST_COMPUTE),
    .expired(wdt_expired)
  );

  assign load_acc = in_valid && in_ready_q && (state_q == ST_LOAD);
  assign wb_acc   = res_valid && res_ready_q && (state_q == ST_WB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_acc) begin
          if (cnt_q == LAST_LOAD) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RF_CNT_W'(1);
          end
        end
      end
      // A completion arriving on the last watchdog cycle still counts as success.
      ST_COMPUTE: begin
        if (calc_done) begin
          state_d = ST_WB;
        end else if (wdt_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WB: begin
        if (wb_acc) begin
          if (cnt_q == LAST_RES) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RF_CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready_d   = (state_d == ST_LOAD);
    res_ready_d  = (state_d == ST_WB);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    calc_start_d = (state_q == ST_LOAD) && (state_d == ST_COMPUTE);
    rf_ra_d      = '0;
    for (int k = 0; k < RF_NREAD; k++) begin
      rf_ra_d[k*ADDR_W +: ADDR_W] = ADDR_W'(SRC_BASE + k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      res_ready_q  <= 1'b0;
      calc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_ra_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      res_ready_q  <= res_ready_d;
      calc_start_q <= calc_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rf_ra_q      <= rf_ra_d;
    end
  end

  // The write port is combinational so an accepted beat lands in the same cycle.
  always_comb begin
    rf_we = !rst && (load_acc || wb_acc);
    rf_wa = '0;
    rf_wd = '0;
    if (rf_we) begin
      if (load_acc) begin
        rf_wa = ADDR_W'(SRC_BASE) + ADDR_W'(cnt_q);
        rf_wd = in_data;
      end else begin
        rf_wa = ADDR_W'(DST_BASE) + ADDR_W'(cnt_q);
        rf_wd = res_data;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign res_ready  = res_ready_q;
  assign calc_start = calc_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rf_ra      = rf_ra_q;

endmodule
